// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and occupancy helpers for the skid pipeline stage
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Beats held in a given state.
  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    case (s)
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// rtl/pipe_data_reg.sv - payload register with async reset, optional sync clear and load enable
module pipe_data_reg #(
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset always zeroes; clear zeroes only when CLEAR_DATA is set and otherwise
  // blocks the load so a flushed beat never lands in the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      if (CLEAR_DATA) begin
        q <= '0;
      end
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with a 2-entry skid buffer and registered in_ready
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  state_t           state_q;
  state_t           state_d;
  logic             in_ready_q;
  logic [OCC_W-1:0] occ_q;
  logic             in_fire;
  logic             out_fire;
  logic             load_main;
  logic             load_skid;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;
  assign main_d    = main_from_skid ? skid_q : in_data;

  // State register; in_ready and occupancy are flopped from the next state so
  // neither output has a combinational path from out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      occ_q      <= occ_of(state_d);
    end
  end

  // Next-state and data-load decode; flush overrides every handshake.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  pipe_data_reg #(
    .WIDTH      (WIDTH),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_data_reg #(
    .WIDTH      (WIDTH),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (load_skid),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid (both CLEAR_DATA variants)
module tb_pipe_stage_skid;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready_c1, out_valid_c1;
  logic [7:0] out_data_c1;
  logic [1:0] occ_c1;
  logic       in_ready_c0, out_valid_c0;
  logic [7:0] out_data_c0;
  logic [1:0] occ_c0;

  int checks;
  int errors;

  pipe_stage_skid #(.WIDTH(8), .CLEAR_DATA(1'b1)) dut_c1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_c1),
    .out_valid (out_valid_c1),
    .out_data  (out_data_c1),
    .out_ready (out_ready),
    .occupancy (occ_c1)
  );

  pipe_stage_skid #(.WIDTH(8), .CLEAR_DATA(1'b0)) dut_c0 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_c0),
    .out_valid (out_valid_c0),
    .out_data  (out_data_c0),
    .out_ready (out_ready),
    .occupancy (occ_c0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against one set of expectations.
  task automatic chk_both(input string tag, input bit ov, input bit [1:0] occ, input bit ir,
                          input bit cd, input bit [7:0] d1, input bit [7:0] d0);
    chk({tag, " c1 out_valid"}, 32'(out_valid_c1), 32'(ov));
    chk({tag, " c1 occupancy"}, 32'(occ_c1), 32'(occ));
    chk({tag, " c1 in_ready"},  32'(in_ready_c1), 32'(ir));
    chk({tag, " c0 out_valid"}, 32'(out_valid_c0), 32'(ov));
    chk({tag, " c0 occupancy"}, 32'(occ_c0), 32'(occ));
    chk({tag, " c0 in_ready"},  32'(in_ready_c0), 32'(ir));
    if (cd) begin
      chk({tag, " c1 out_data"}, 32'(out_data_c1), 32'(d1));
      chk({tag, " c0 out_data"}, 32'(out_data_c0), 32'(d0));
    end
  endtask

  typedef struct {
    bit       iv;
    bit [7:0] d;
    bit       ordy;
    bit       fl;
    bit       ov;
    bit [1:0] occ;
    bit       ir;
    bit       cd;
    bit [7:0] d1;
    bit [7:0] d0;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(bit iv, bit [7:0] d, bit ordy, bit fl, bit ov, bit [1:0] occ,
                              bit ir, bit cd, bit [7:0] d1, bit [7:0] d0);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.ov = ov; v.occ = occ;
    v.ir = ir; v.cd = cd; v.d1 = d1; v.d0 = d0;
    return v;
  endfunction

  logic [7:0] mq[$];
  bit         exp_ir;
  bit         m_in_fire;
  bit         m_out_fire;
  logic       ir_lo;
  logic       ir_hi;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Expected outputs after the edge that applies each row's inputs.
    tbl[0]  = mk(1, 8'h11, 1, 0,  1, 2'd1, 1,  1, 8'h11, 8'h11);
    tbl[1]  = mk(1, 8'h22, 1, 0,  1, 2'd1, 1,  1, 8'h22, 8'h22);
    tbl[2]  = mk(1, 8'h33, 1, 0,  1, 2'd1, 1,  1, 8'h33, 8'h33);
    tbl[3]  = mk(0, 8'h00, 1, 0,  0, 2'd0, 1,  0, 8'h00, 8'h00);
    tbl[4]  = mk(1, 8'hA0, 0, 0,  1, 2'd1, 1,  1, 8'hA0, 8'hA0);
    tbl[5]  = mk(1, 8'hA1, 0, 0,  1, 2'd2, 0,  1, 8'hA0, 8'hA0);
    tbl[6]  = mk(1, 8'hA2, 0, 0,  1, 2'd2, 0,  1, 8'hA0, 8'hA0);
    tbl[7]  = mk(1, 8'hA2, 1, 0,  1, 2'd1, 1,  1, 8'hA1, 8'hA1);
    tbl[8]  = mk(1, 8'hA2, 1, 0,  1, 2'd1, 1,  1, 8'hA2, 8'hA2);
    tbl[9]  = mk(0, 8'h00, 1, 0,  0, 2'd0, 1,  0, 8'h00, 8'h00);
    tbl[10] = mk(1, 8'h09, 0, 0,  1, 2'd1, 1,  1, 8'h09, 8'h09);
    tbl[11] = mk(1, 8'h0B, 1, 0,  1, 2'd1, 1,  1, 8'h0B, 8'h0B);
    tbl[12] = mk(0, 8'h00, 1, 0,  0, 2'd0, 1,  0, 8'h00, 8'h00);
    tbl[13] = mk(1, 8'h05, 0, 0,  1, 2'd1, 1,  1, 8'h05, 8'h05);
    tbl[14] = mk(1, 8'h06, 0, 0,  1, 2'd2, 0,  1, 8'h05, 8'h05);
    tbl[15] = mk(1, 8'h07, 0, 1,  0, 2'd0, 1,  1, 8'h00, 8'h05);
    tbl[16] = mk(0, 8'h00, 1, 0,  0, 2'd0, 1,  1, 8'h00, 8'h05);
    tbl[17] = mk(1, 8'h0C, 0, 0,  1, 2'd1, 1,  1, 8'h0C, 8'h0C);
    tbl[18] = mk(0, 8'h00, 1, 0,  0, 2'd0, 1,  0, 8'h00, 8'h00);

    // Reset state while rst is held.
    #12;
    chk_both("reset", 1'b0, 2'd0, 1'b1, 1'b1, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      @(posedge clk);
      #1;
      chk_both($sformatf("vec%0d", i), tbl[i].ov, tbl[i].occ, tbl[i].ir, tbl[i].cd,
               tbl[i].d1, tbl[i].d0);
    end

    // Fill to FULL, then assert rst between edges: outputs must clear at once.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    in_data = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    chk_both("prefull", 1'b1, 2'd2, 1'b0, 1'b1, 8'h44, 8'h44);
    #2;
    rst = 1'b1;
    #1;
    chk_both("async_rst", 1'b0, 2'd0, 1'b1, 1'b1, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against a queue model of the stage.
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 4) < 3);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      exp_ir = (mq.size() < 2);
      chk("rnd c1 out_valid", 32'(out_valid_c1), 32'(mq.size() > 0));
      chk("rnd c0 out_valid", 32'(out_valid_c0), 32'(mq.size() > 0));
      chk("rnd c1 occupancy", 32'(occ_c1), 32'(mq.size()));
      chk("rnd c0 occupancy", 32'(occ_c0), 32'(mq.size()));
      chk("rnd c1 in_ready", 32'(in_ready_c1), 32'(exp_ir));
      chk("rnd c0 in_ready", 32'(in_ready_c0), 32'(exp_ir));
      if (mq.size() > 0) begin
        chk("rnd c1 out_data", 32'(out_data_c1), 32'(mq[0]));
        chk("rnd c0 out_data", 32'(out_data_c0), 32'(mq[0]));
      end
      if (mq.size() == 2) begin
        // Toggle out_ready within the cycle; in_ready must not follow it.
        out_ready = 1'b0;
        #1;
        ir_lo = in_ready_c1;
        out_ready = 1'b1;
        #1;
        ir_hi = in_ready_c1;
        chk("comb in_ready lo", 32'(ir_lo), 32'(exp_ir));
        chk("comb in_ready hi", 32'(ir_hi), 32'(exp_ir));
        out_ready = ($urandom_range(0, 1) != 0);
      end
      m_in_fire  = in_valid && exp_ir;
      m_out_fire = out_ready && (mq.size() > 0);
      @(posedge clk);
      if (flush) begin
        mq.delete();
      end else begin
        if (m_out_fire) void'(mq.pop_front());
        if (m_in_fire) mq.push_back(in_data);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
